// File: rtl/credit_counter_if.sv
// Credit counter bus: consumer take/take_ok, producer return count and status flags.
// The master modport is the allocating/freeing logic; the slave modport is the counter.
// With CREDIT_COUNTER_ERR_EN defined the bus also carries the sticky err_underflow/err_overflow flags.
interface credit_counter_if #(
  parameter int WIDTH     = 4,
  parameter int RET_WIDTH = 2
);
  logic                 flush;
  logic                 take;
  logic                 take_ok;
  logic [RET_WIDTH-1:0] ret_cnt;
  logic [WIDTH-1:0]     credits;
  logic                 empty;
  logic                 low;
  logic                 full;
`ifdef CREDIT_COUNTER_ERR_EN
  logic                 err_underflow;
  logic                 err_overflow;

  modport master (
    output flush, take, ret_cnt,
    input  take_ok, credits, empty, low, full, err_underflow, err_overflow
  );

  modport slave (
    input  flush, take, ret_cnt,
    output take_ok, credits, empty, low, full, err_underflow, err_overflow
  );
`else
  modport master (
    output flush, take, ret_cnt,
    input  take_ok, credits, empty, low, full
  );

  modport slave (
    input  flush, take, ret_cnt,
    output take_ok, credits, empty, low, full
  );
`endif
endinterface

// File: rtl/credit_counter.sv
// Down-counting credit tracker for an OOO resource pool: one take per cycle, bulk returns, saturating at MAX_CREDITS.
// Optional macro CREDIT_COUNTER_ERR_EN adds sticky err_underflow/err_overflow flags.
module credit_counter #(
  parameter int WIDTH       = 4,
  parameter int MAX_CREDITS = 8,
  parameter int RET_WIDTH   = 2,
  parameter int LOW_MARK    = 2
) (
  input  logic               clk,
  input  logic               rst_aH,
  credit_counter_if.slave    bus
);

  // Wide enough that credits + ret_cnt can never wrap before the saturation compare.
  localparam int SUM_W = ((WIDTH > RET_WIDTH) ? WIDTH : RET_WIDTH) + 1;

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MAX_CREDITS);
  localparam logic [WIDTH-1:0] LOW_VAL = WIDTH'(LOW_MARK);
  localparam logic [SUM_W-1:0] MAX_SUM = SUM_W'(MAX_CREDITS);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic [SUM_W-1:0] sum;
  logic             empty;
  logic             take_ok;
  logic             overflow_evt;
  logic             underflow_evt;

  assign empty   = (count_q == '0);
  assign take_ok = bus.take & ~empty & ~bus.flush & ~rst_aH;

  // Status flags decode the register directly so dispatch sees them with no added latency.
  assign bus.credits = count_q;
  assign bus.empty   = empty;
  assign bus.low     = (count_q <= LOW_VAL);
  assign bus.full    = (count_q == MAX_VAL);
  assign bus.take_ok = take_ok;

  // take_ok is zero whenever the count is zero, so the subtraction cannot go negative.
  always_comb begin
    sum           = SUM_W'(count_q) - SUM_W'(take_ok) + SUM_W'(bus.ret_cnt);
    overflow_evt  = ~bus.flush & (sum > MAX_SUM);
    underflow_evt = ~bus.flush & bus.take & empty;
    if (bus.flush || overflow_evt) begin
      count_d = MAX_VAL;
    end else begin
      count_d = sum[WIDTH-1:0];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst_aH) begin
    if (rst_aH) begin
      count_q <= MAX_VAL;
    end else begin
      count_q <= count_d;
    end
  end

`ifdef CREDIT_COUNTER_ERR_EN
  logic err_underflow_q;
  logic err_overflow_q;

  // Sticky until reset or flush; a flush in the same cycle as an event keeps the flag clear.
  always_ff @(posedge clk or posedge rst_aH) begin
    if (rst_aH) begin
      err_underflow_q <= 1'b0;
      err_overflow_q  <= 1'b0;
    end else if (bus.flush) begin
      err_underflow_q <= 1'b0;
      err_overflow_q  <= 1'b0;
    end else begin
      err_underflow_q <= err_underflow_q | underflow_evt;
      err_overflow_q  <= err_overflow_q  | overflow_evt;
    end
  end

  assign bus.err_underflow = err_underflow_q;
  assign bus.err_overflow  = err_overflow_q;
`else
  logic unused_evt;
  assign unused_evt = overflow_evt ^ underflow_evt;
`endif

endmodule

// File: tb/tb_credit_counter.sv
// Directed and random self-checking bench for credit_counter (MAX_CREDITS=8, LOW_MARK=2, RET_WIDTH=2).
// Checks err flags too when CREDIT_COUNTER_ERR_EN is defined.
module tb_credit_counter;

  localparam int MAXC = 8;
  localparam int LOWM = 2;

  logic clk;
  logic rst_aH;
  int   checks;
  int   failures;

  credit_counter_if #(.WIDTH(4), .RET_WIDTH(2)) bus ();

  credit_counter #(
    .WIDTH(4), .MAX_CREDITS(MAXC), .RET_WIDTH(2), .LOW_MARK(LOWM)
  ) dut (
    .clk    (clk),
    .rst_aH (rst_aH),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply inputs on the falling edge, settle, then sample combinational outputs.
  task automatic drive(input logic tk, input logic [1:0] ret, input logic fl);
    @(negedge clk);
    bus.take    = tk;
    bus.ret_cnt = ret;
    bus.flush   = fl;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string name, input int exp);
    checks++;
    if (bus.credits !== 4'(exp)) begin
      failures++;
      $display("FAIL %s credits: got %0d expected %0d", name, bus.credits, exp);
    end
    checks++;
    if (bus.empty !== (exp == 0) || bus.low !== (exp <= LOWM) || bus.full !== (exp == MAXC)) begin
      failures++;
      $display("FAIL %s flags e/l/f: got %b%b%b expected %b%b%b", name, bus.empty, bus.low,
               bus.full, exp == 0, exp <= LOWM, exp == MAXC);
    end
  endtask

  task automatic test_reset();
    rst_aH = 1'b1;
    bus.take = 1'b0; bus.ret_cnt = 2'd0; bus.flush = 1'b0;
    #12;
    check_state("reset_initial", MAXC);
    @(negedge clk);
    rst_aH = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 2'd0, 1'b0);
      tick();
    end
    check_state("pre_reset_3", 3);
    // Assert reset between edges with a take pending.
    drive(1'b1, 2'd0, 1'b0);
    #1 rst_aH = 1'b1;
    #1;
    check_state("reset_async", MAXC);
    checks++;
    if (bus.take_ok !== 1'b0) begin
      failures++;
      $display("FAIL reset_take_ok: got %b expected 0", bus.take_ok);
    end
`ifdef CREDIT_COUNTER_ERR_EN
    checks++;
    if (bus.err_underflow !== 1'b0 || bus.err_overflow !== 1'b0) begin
      failures++;
      $display("FAIL reset_err: got %b%b expected 00", bus.err_underflow, bus.err_overflow);
    end
`endif
    tick();
    check_state("reset_held", MAXC);
    drive(1'b0, 2'd0, 1'b0);
    rst_aH = 1'b0;
  endtask

  task automatic test_drain();
    for (int i = 1; i <= MAXC; i++) begin
      drive(1'b1, 2'd0, 1'b0);
      checks++;
      if (bus.take_ok !== 1'b1) begin
        failures++;
        $display("FAIL drain_take_ok step %0d: got %b expected 1", i, bus.take_ok);
      end
      tick();
      check_state($sformatf("drain_%0d", i), MAXC - i);
    end
    drive(1'b1, 2'd0, 1'b0);
    checks++;
    if (bus.take_ok !== 1'b0) begin
      failures++;
      $display("FAIL drain_underflow_take_ok: got %b expected 0", bus.take_ok);
    end
    tick();
    check_state("drain_underflow", 0);
`ifdef CREDIT_COUNTER_ERR_EN
    checks++;
    if (bus.err_underflow !== 1'b1) begin
      failures++;
      $display("FAIL drain_err_underflow: got %b expected 1", bus.err_underflow);
    end
`endif
  endtask

  task automatic test_simultaneous();
    // Empty: take dropped, returns still land.
    drive(1'b1, 2'd3, 1'b0);
    checks++;
    if (bus.take_ok !== 1'b0) begin
      failures++;
      $display("FAIL simul_empty_take_ok: got %b expected 0", bus.take_ok);
    end
    tick();
    check_state("simul_empty_ret3", 3);
    drive(1'b1, 2'd2, 1'b0);
    checks++;
    if (bus.take_ok !== 1'b1) begin
      failures++;
      $display("FAIL simul_take_ok: got %b expected 1", bus.take_ok);
    end
    tick();
    check_state("simul_3_take_ret2", 4);
  endtask

  task automatic test_saturation();
    drive(1'b0, 2'd3, 1'b0);
    tick();
    check_state("sat_to_7", 7);
`ifdef CREDIT_COUNTER_ERR_EN
    checks++;
    if (bus.err_overflow !== 1'b0) begin
      failures++;
      $display("FAIL sat_no_overflow_yet: got %b expected 0", bus.err_overflow);
    end
`endif
    drive(1'b0, 2'd3, 1'b0);
    tick();
    check_state("sat_7_ret3", MAXC);
`ifdef CREDIT_COUNTER_ERR_EN
    checks++;
    if (bus.err_overflow !== 1'b1) begin
      failures++;
      $display("FAIL sat_err_overflow: got %b expected 1", bus.err_overflow);
    end
`endif
    drive(1'b0, 2'd3, 1'b0);
    tick();
    check_state("sat_full_ret3", MAXC);
  endtask

  task automatic test_flush_priority();
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 2'd0, 1'b0);
      tick();
    end
    check_state("flush_pre_1", 1);
    drive(1'b1, 2'd1, 1'b1);
    checks++;
    if (bus.take_ok !== 1'b0) begin
      failures++;
      $display("FAIL flush_take_ok: got %b expected 0", bus.take_ok);
    end
    tick();
    check_state("flush_restore", MAXC);
`ifdef CREDIT_COUNTER_ERR_EN
    checks++;
    if (bus.err_underflow !== 1'b0 || bus.err_overflow !== 1'b0) begin
      failures++;
      $display("FAIL flush_err_clear: got %b%b expected 00", bus.err_underflow, bus.err_overflow);
    end
`endif
    drive(1'b0, 2'd0, 1'b0);
  endtask

  task automatic test_random_soak();
    int   m = MAXC;
    logic tk;
    logic fl;
    logic [1:0] ret;
    int   s;
    bit   exp_ok;
    bit   uf = 1'b0;
    bit   of = 1'b0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      fl = ($urandom_range(0, 31) == 0);
      // Alternate between draining and refilling phases so both ends get exercised.
      if ((cyc / 200) % 2 == 0) begin
        tk  = ($urandom_range(0, 3) != 0);
        ret = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'd0;
      end else begin
        tk  = ($urandom_range(0, 3) == 0);
        ret = 2'($urandom_range(0, 3));
      end
      drive(tk, ret, fl);
      exp_ok = tk && (m > 0) && !fl;
      checks++;
      if (bus.take_ok !== exp_ok) begin
        failures++;
        $display("FAIL soak_take_ok cyc %0d: got %b expected %b", cyc, bus.take_ok, exp_ok);
      end
      if (fl) begin
        m  = MAXC;
        uf = 1'b0;
        of = 1'b0;
      end else begin
        s  = m - int'(exp_ok) + int'(ret);
        uf = uf | (tk && m == 0);
        of = of | (s > MAXC);
        m  = (s > MAXC) ? MAXC : s;
      end
      tick();
      check_state($sformatf("soak_%0d", cyc), m);
      checks++;
      if (bus.credits > 4'(MAXC)) begin
        failures++;
        $display("FAIL soak_range cyc %0d: got %0d expected <= %0d", cyc, bus.credits, MAXC);
      end
`ifdef CREDIT_COUNTER_ERR_EN
      checks++;
      if (bus.err_underflow !== uf || bus.err_overflow !== of) begin
        failures++;
        $display("FAIL soak_err cyc %0d: got %b%b expected %b%b", cyc, bus.err_underflow,
                 bus.err_overflow, uf, of);
      end
`endif
    end
    drive(1'b0, 2'd0, 1'b0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_drain();
    test_simultaneous();
    test_saturation();
    test_flush_priority();
    test_random_soak();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
